event_delay_monitor: RTL and testbench

- Clocked, synthesizable counterpart of the behavioural max-delay timing checks.
- Sits directly downstream of the rise/fall delay elements in the 802.3da PHY/PLCA model.
- Measures, in clock cycles, the delay from a rising edge on `event1` (delay-element input side) to the next rising edge on `event2` (delay-element output side).
- Reports each measurement, flags min/max window violations and keeps a saturating violation count, so checks survive into emulation/FPGA builds where `$time` monitors do not exist.

---
 rtl/event_delay_monitor.sv | 132 +++++++++++++
 tb/tb_event_delay_monitor.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/event_delay_monitor.sv
// event_delay_monitor: clocked max/min delay check from event1 rise to next event2 rise
// Ports: clk, reset (async, active-high), enable, clear (sync), event1/event2 (start/end events);
//        busy, delay_count, measure_valid, max_violation, min_violation, violation_count.
// Build option: EVENT_SYNC_EN adds a 2-flop synchronizer per event input; otherwise a single
// capture flop is used and the events must already be synchronous to clk.
module event_delay_monitor #(
    parameter int CNT_WIDTH = 16,
    parameter int MAX_DELAY = 100,
    parameter int MIN_DELAY = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 event1,
    input  logic                 event2,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] delay_count,
    output logic                 measure_valid,
    output logic                 max_violation,
    output logic                 min_violation,
    output logic [7:0]           violation_count
);
    localparam logic [1:0] IDLE = 2'd0, ARMED = 2'd1, TIMEOUT = 2'd2;
    localparam logic [CNT_WIDTH-1:0] MAX_C = CNT_WIDTH'(MAX_DELAY);
    localparam logic [CNT_WIDTH-1:0] MIN_C = CNT_WIDTH'(MIN_DELAY);

    logic cur1, cur2, prev1, prev2, rise1, rise2;
`ifdef EVENT_SYNC_EN
    logic [1:0] sync1, sync2;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sync1[0], event1};
            sync2 <= {sync2[0], event2};
        end
    assign cur1 = sync1[1];
    assign cur2 = sync2[1];
`else
    logic cap1, cap2;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cap1 <= 1'b0;
            cap2 <= 1'b0;
        end else begin
            cap1 <= event1;
            cap2 <= event2;
        end
    assign cur1 = cap1;
    assign cur2 = cap2;
`endif

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            prev1 <= 1'b0;
            prev2 <= 1'b0;
        end else begin
            prev1 <= cur1;
            prev2 <= cur2;
        end
    assign rise1 = cur1 & ~prev1;
    assign rise2 = cur2 & ~prev2;

    logic [1:0]           state, state_n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n, inc, dc_n;
    logic                 mv_n, maxv_n, minv_n, under_min;
    logic [7:0]           vc_n;

    // Saturating increment; only reaches all-ones while in TIMEOUT.
    assign inc = (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
    // Borrow of inc - MIN_C, i.e. inc < MIN_DELAY, without a constant compare when MIN_DELAY is 0.
    assign under_min = 1'(({1'b0, inc} - {1'b0, MIN_C}) >> CNT_WIDTH);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dc_n    = delay_count;
        mv_n    = 1'b0;
        maxv_n  = 1'b0;
        minv_n  = 1'b0;
        if (!enable) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else if (state == IDLE) begin
            if (rise1) begin
                state_n = ARMED;
                cnt_n   = '0;
            end
        end else begin
            cnt_n = inc;
            if (rise2) begin
                dc_n    = inc;
                mv_n    = 1'b1;
                minv_n  = (state == ARMED) && under_min;
                state_n = IDLE;
            end else if (state == ARMED && !rise1 && inc > MAX_C) begin
                maxv_n  = 1'b1;
                state_n = TIMEOUT;
            end
            // A new start event wins over the end of the old measurement.
            if (rise1) begin
                state_n = ARMED;
                cnt_n   = '0;
            end
        end
        vc_n = clear ? 8'd0 : ((maxv_n | minv_n) && violation_count != 8'hff) ? violation_count + 8'd1 : violation_count;
        if (clear) dc_n = '0;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            busy            <= 1'b0;
            delay_count     <= '0;
            measure_valid   <= 1'b0;
            max_violation   <= 1'b0;
            min_violation   <= 1'b0;
            violation_count <= '0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            busy            <= state_n != IDLE;
            delay_count     <= dc_n;
            measure_valid   <= mv_n;
            max_violation   <= maxv_n;
            min_violation   <= minv_n;
            violation_count <= vc_n;
        end
endmodule

// File: tb/tb_event_delay_monitor.sv
// tb_event_delay_monitor: directed self-checking bench for event_delay_monitor
module tb_event_delay_monitor;
    localparam int MAXD = 10, MIND = 2;
    logic        clk = 1'b0, reset, enable, clear, event1, event2;
    logic        busy, measure_valid, max_violation, min_violation;
    logic [15:0] delay_count;
    logic [7:0]  violation_count;
    int checks = 0, failures = 0;
    int cyc = 0, mv_n = 0, maxv_n = 0, minv_n = 0, max_cyc = 0;
    int b_mv, b_maxv, b_minv, t0;

    event_delay_monitor #(.CNT_WIDTH(16), .MAX_DELAY(MAXD), .MIN_DELAY(MIND)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .event1(event1), .event2(event2), .busy(busy), .delay_count(delay_count),
        .measure_valid(measure_valid), .max_violation(max_violation),
        .min_violation(min_violation), .violation_count(violation_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (measure_valid) mv_n <= mv_n + 1;
        if (min_violation) minv_n <= minv_n + 1;
        if (max_violation) begin
            maxv_n  <= maxv_n + 1;
            max_cyc <= cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        b_mv   = mv_n;
        b_maxv = maxv_n;
        b_minv = minv_n;
    endtask

    // event1 rises now, event2 rises k cycles later, both then return low.
    task automatic run(input int k);
        event1 = 1'b1;
        repeat (k) tick();
        event2 = 1'b1;
        tick();
        event1 = 1'b0;
        repeat (4) tick();
        event2 = 1'b0;
        repeat (2) tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clear = 1'b0; event1 = 1'b0; event2 = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_dc", delay_count, 0);
        chk("rst_mv", measure_valid, 0);
        chk("rst_vc", violation_count, 0);
        reset = 1'b0;
        repeat (2) tick();

        snap();
        run(5);
        chk("d5_dc", delay_count, 5);
        chk("d5_mv", mv_n - b_mv, 1);
        chk("d5_viol", (maxv_n - b_maxv) + (minv_n - b_minv), 0);
        chk("d5_busy", busy, 0);
        chk("d5_vc", violation_count, 0);

        snap();
        run(1);
        chk("d1_dc", delay_count, 1);
        chk("d1_min", minv_n - b_minv, 1);
        chk("d1_vc", violation_count, 1);

        snap();
        event1 = 1'b1;
        t0 = cyc;
        repeat (15) tick();
        chk("to_busy", busy, 1);
        chk("to_max", maxv_n - b_maxv, 1);
        chk("to_when", max_cyc - t0, MAXD + 3);
        repeat (5) tick();
        event2 = 1'b1;
        event1 = 1'b0;
        repeat (4) tick();
        event2 = 1'b0;
        repeat (2) tick();
        chk("to_dc", delay_count, 20);
        chk("to_mv", mv_n - b_mv, 1);
        chk("to_max2", maxv_n - b_maxv, 1);
        chk("to_vc", violation_count, 2);
        chk("to_idle", busy, 0);

        snap();
        event1 = 1'b1;
        tick();
        event1 = 1'b0;
        repeat (2) tick();
        event1 = 1'b1;
        repeat (4) tick();
        event2 = 1'b1;
        tick();
        event1 = 1'b0;
        repeat (4) tick();
        event2 = 1'b0;
        repeat (2) tick();
        chk("rs_dc", delay_count, 4);
        chk("rs_mv", mv_n - b_mv, 1);
        chk("rs_viol", (maxv_n - b_maxv) + (minv_n - b_minv), 0);

        snap();
        event1 = 1'b1;
        event2 = 1'b1;
        repeat (3) tick();
        chk("sim_busy", busy, 1);
        enable = 1'b0;
        tick();
        chk("en_busy", busy, 0);
        enable = 1'b1;
        event1 = 1'b0;
        event2 = 1'b0;
        repeat (3) tick();
        chk("sim_mv", mv_n - b_mv, 0);
        chk("en_dc", delay_count, 4);
        chk("en_vc", violation_count, 2);

        event1 = 1'b1;
        repeat (3) tick();
        chk("ra_busy", busy, 1);
        snap();
        #2 reset = 1'b1;
        #1;
        chk("ra_busy0", busy, 0);
        chk("ra_dc", delay_count, 0);
        chk("ra_vc", violation_count, 0);
        chk("ra_pulses", {29'd0, measure_valid, max_violation, min_violation}, 0);
        event1 = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (15) tick();
        chk("ra_nopulse", (mv_n - b_mv) + (maxv_n - b_maxv) + (minv_n - b_minv), 0);
        chk("ra_idle", busy, 0);

        for (int i = 0; i < 300; i++) run(1);
        chk("sat_vc", violation_count, 255);
        chk("sat_dc", delay_count, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        chk("clr_vc", violation_count, 0);
        chk("clr_dc", delay_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
